// File: rtl/bcd_display_formatter_if.sv
// Signal bundle between a conversion requester and bcd_display_formatter.
// Handshake: start is sampled only while busy is low; done pulses one cycle when i7..i0/ovf update.
interface bcd_display_formatter_if #(
  parameter int WIDTH = 27
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             dp_en;
  logic [2:0]       dp_sel;
  logic             blank_lz;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [5:0]       i7, i6, i5, i4, i3, i2, i1, i0;
  logic [1:0]       state_dbg;

  modport master (
    output start, bin, dp_en, dp_sel, blank_lz,
    input  busy, done, ovf, i7, i6, i5, i4, i3, i2, i1, i0, state_dbg
  );

  modport slave (
    input  start, bin, dp_en, dp_sel, blank_lz,
    output busy, done, ovf, i7, i6, i5, i4, i3, i2, i1, i0, state_dbg
  );
endinterface

// File: rtl/bcd_display_formatter.sv
// Binary to 8-digit BCD (double-dabble, one bit per cycle) with seven-segment digit packing,
// leading-zero blanking and decimal-point placement.
module bcd_display_formatter #(
  parameter int WIDTH = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_display_formatter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] bin_reg;
  logic [31:0]      bcd, bcd_adj;
  logic [4:0]       cnt;
  logic             dp_en_r, blank_lz_r, ovf_pend;
  logic [2:0]       dp_sel_r;
  logic [5:0]       word [8];
  logic             lead_zero;
  logic [5:0]       out_r [8];
  logic             ovf_r, done_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 8; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  // Digit words; lead_zero tracks "all BCD digits from 7 down to k are zero".
  always_comb begin
    lead_zero = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      lead_zero = lead_zero && (bcd[4*k +: 4] == 4'd0);
      if ((k != 0) && blank_lz_r && !ovf_pend && lead_zero &&
          !(dp_en_r && (3'(k) <= dp_sel_r)))
        word[k] = 6'h00;
      else
        word[k] = {1'b1, (ovf_pend ? 4'd9 : bcd[4*k +: 4]), (dp_en_r && (dp_sel_r == 3'(k)))};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_reg    <= '0;
      bcd        <= '0;
      cnt        <= '0;
      dp_en_r    <= 1'b0;
      dp_sel_r   <= '0;
      blank_lz_r <= 1'b0;
      ovf_pend   <= 1'b0;
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      for (int k = 0; k < 8; k++) out_r[k] <= 6'h00;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_reg    <= bus.bin;
            dp_en_r    <= bus.dp_en;
            dp_sel_r   <= bus.dp_sel;
            blank_lz_r <= bus.blank_lz;
            ovf_pend   <= (32'(bus.bin) > 32'd99_999_999);
            bcd        <= '0;
            cnt        <= 5'(WIDTH);
          end
        end
        SHIFT: begin
          {bcd, bin_reg} <= {bcd_adj, bin_reg} << 1;
          cnt            <= cnt - 5'd1;
        end
        PACK: begin
          for (int k = 0; k < 8; k++) out_r[k] <= word[k];
          ovf_r  <= ovf_pend;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.ovf       = ovf_r;
  assign bus.state_dbg = state;
  assign bus.i0 = out_r[0];
  assign bus.i1 = out_r[1];
  assign bus.i2 = out_r[2];
  assign bus.i3 = out_r[3];
  assign bus.i4 = out_r[4];
  assign bus.i5 = out_r[5];
  assign bus.i6 = out_r[6];
  assign bus.i7 = out_r[7];

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Randomized and directed bench for bcd_display_formatter against a decimal-arithmetic model.
module tb_bcd_display_formatter;
  localparam int WIDTH = 27;
  localparam int W     = 49;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_display_formatter_if #(.WIDTH(WIDTH)) bus();

  bcd_display_formatter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ovf, i7..i0} from plain decimal arithmetic.
  function automatic logic [W-1:0] model(input longint v, input bit de, input int ds, input bit bl);
    logic [W-1:0] r;
    longint p;
    int d;
    bit ovf, blank;
    ovf   = (v > 64'd99_999_999);
    r     = '0;
    r[48] = ovf;
    p     = 1;
    for (int k = 0; k < 8; k++) begin
      d     = ovf ? 9 : int'((v / p) % 10);
      blank = bl && !ovf && (k >= 1) && (v < p) && !(de && k <= ds);
      r[6*k +: 6] = blank ? 6'h00 : {1'b1, 4'(d), (de && ds == k)};
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.ovf, bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};
  endfunction

  task automatic scramble();
    bus.bin      = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    bus.dp_en    = 1'($urandom_range(0, 1));
    bus.dp_sel   = 3'($urandom_range(0, 7));
    bus.blank_lz = 1'($urandom_range(0, 1));
  endtask

  // Drives inputs at a negedge so start is sampled on the following rising edge.
  task automatic launch(input int unsigned b, input bit de, input int ds, input bit bl);
    bus.bin      = WIDTH'(b);
    bus.dp_en    = de;
    bus.dp_sel   = 3'(ds);
    bus.blank_lz = bl;
    bus.start    = 1'b1;
    exp_q.push_back(model(longint'(b), de, ds, bl));
  endtask

  // Returns at the negedge of the done cycle; n-1 counts rising edges after the start edge.
  task automatic wait_done(input string tag, input bit poke);
    logic [W-1:0] exp;
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        check({tag, " latency"}, 64'(n - 1), 64'd28);
        check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
        if (exp_q.size() == 0) check({tag, " queue"}, 64'd1, 64'd0);
        else begin
          exp = exp_q.pop_front();
          check({tag, " digits"}, 64'(observed()), 64'(exp));
        end
      end else begin
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        scramble();
        if (poke && n == 5) bus.start = 1'b1;
        if (poke && n == 6) bus.start = 1'b0;
      end
    end
    if (!seen) begin
      check({tag, " done_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic settle(input string tag);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check({tag, " idle"}, {62'd0, bus.done, bus.busy}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones;
    int unsigned b;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.bin      = '0;
    bus.dp_en    = 1'b0;
    bus.dp_sel   = '0;
    bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 64'(observed()), 64'd0);
    check("reset busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    launch(1234, 0, 0, 1);
    wait_done("bin1234", 0);
    check("bin1234 i0", 64'(bus.i0), 64'h28);
    check("bin1234 i3", 64'(bus.i3), 64'h22);
    settle("bin1234");

    launch(0, 0, 0, 1);              wait_done("zero_blank", 0);   settle("zero_blank");
    launch(0, 0, 0, 0);              wait_done("zero_noblank", 0); settle("zero_noblank");
    launch(50, 1, 2, 1);             wait_done("dp_050", 0);
    check("dp_050 i2", 64'(bus.i2), 64'h21);
    settle("dp_050");
    launch(123_456_789, 0, 0, 1);    wait_done("ovf", 0);
    check("ovf i7", 64'(bus.i7), 64'h32);
    settle("ovf");
    launch(99_999_999, 0, 0, 1);     wait_done("max", 0);          settle("max");
    launch(100_000_000, 1, 7, 1);    wait_done("max_plus1", 0);    settle("max_plus1");
    launch(7, 1, 0, 1);              wait_done("dp0", 0);          settle("dp0");

    launch(7_654_321, 1, 5, 1);      wait_done("ignored_start", 1); settle("ignored_start");

    launch(10_203, 0, 0, 1);         wait_done("chain_a", 0);
    launch(98_765_432, 1, 3, 0);     wait_done("chain_b", 0);      settle("chain_b");

    launch(4321, 0, 0, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort outputs", 64'(observed()), 64'd0);
    check("abort busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'd0);
    launch(86_420, 1, 1, 1);         wait_done("after_reset", 0);  settle("after_reset");

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 999);
        1:       b = $urandom_range(99_999_990, 100_000_010);
        2:       b = $urandom_range(0, (1 << WIDTH) - 1);
        default: b = $urandom_range(0, 10 ** $urandom_range(1, 8));
      endcase
      launch(b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wait_done("random", 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) settle("random");
    end
    settle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
